// File: rtl/qam_linear_interp.sv
// qam_linear_interp: symbol-to-sample linear interpolating upsampler (define QAM_INTERP_ROUND_EN for round-half-up output)
module qam_linear_interp #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sym_in,
    input  logic         sym_valid,
    output logic         sym_ready,
    output logic [W-1:0] sample_out,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic [15:0]  underrun_cnt
);
    localparam int L = $clog2(N);
    localparam logic signed [W+L:0] HALF = (W+L+1)'(N/2);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [W-1:0] prev, prev_n, cur, cur_n, base;
    logic signed [W:0] delta, delta_n;
    logic signed [W+L:0] acc, acc_n;
    logic [L-1:0] k, k_n;
    logic [15:0] underrun_n;
    logic last, sym_xfer, smp_xfer;
    assign last = &k;
    assign sample_valid = state == RUN;
    assign sym_ready = (state == IDLE) ? 1'b1 : last & sample_ready;
    assign sym_xfer = sym_valid & sym_ready;
    assign smp_xfer = sample_valid & sample_ready;
    assign base = (state == IDLE) ? prev : cur;
`ifdef QAM_INTERP_ROUND_EN
    assign sample_out = W'((acc + HALF) >>> L);
`else
    assign sample_out = W'(acc >>> L);
`endif
    // next-state: a symbol load ramps from the last symbol; otherwise step the ramp or fall idle
    always_comb begin
        state_n = state;
        prev_n = prev;
        cur_n = cur;
        delta_n = delta;
        acc_n = acc;
        k_n = k;
        underrun_n = underrun_cnt;
        if (sym_xfer) begin
            prev_n = base;
            cur_n = sym_in;
            delta_n = {sym_in[W-1], sym_in} - {base[W-1], base};
            acc_n = {base[W-1], base, {L{1'b0}}};
            k_n = '0;
            state_n = RUN;
        end else if (smp_xfer) begin
            if (last) begin
                prev_n = cur;
                state_n = IDLE;
                underrun_n = &underrun_cnt ? underrun_cnt : underrun_cnt + 16'd1;
            end else begin
                acc_n = acc + {{L{delta[W]}}, delta};
                k_n = k + L'(1);
            end
        end
    end
    // state registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prev <= '0;
            cur <= '0;
            delta <= '0;
            acc <= '0;
            k <= '0;
            underrun_cnt <= '0;
        end else begin
            state <= state_n;
            prev <= prev_n;
            cur <= cur_n;
            delta <= delta_n;
            acc <= acc_n;
            k <= k_n;
            underrun_cnt <= underrun_n;
        end
    end
endmodule
